cve2_imem_responder: RTL



---
 rtl/cve2_imem_pkg.sv | 14 +
 rtl/cve2_imem_resp_pipe.sv | 101 ++++++++++
 rtl/cve2_imem_responder.sv | 60 ++++++
 3 files changed

// File: rtl/cve2_imem_pkg.sv
// Shared types and limits for the instruction-memory responder.
package cve2_imem_pkg;

  // Deepest response pipeline the responder can be built with.
  localparam int unsigned MaxReadLatency = 4;

  // One slot of the response pipeline.
  typedef struct packed {
    logic        valid;
    logic        err;
    logic [31:0] data;
  } imem_stage_t;

endpackage

// File: rtl/cve2_imem_resp_pipe.sv
// Fixed-latency response pipeline.
// The head slot records {valid, err} in the cycle after the accept, which
// is also when the SRAM data appears. The head is resolved into
// {valid, err, data} there. With one cycle of latency, that resolved head
// drives the output directly. Otherwise it is shifted through
// ReadLatency-1 registered stages. No backpressure exists, so every
// stage advances every cycle.
module cve2_imem_resp_pipe
  import cve2_imem_pkg::*;
#(
  parameter int unsigned ReadLatency = 1,
  parameter logic [31:0] ErrRdata    = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  input  logic        in_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rvalid_o,
  output logic        err_o,
  output logic [31:0] rdata_o,
  output logic        busy_o
);

  if (ReadLatency < 1 || ReadLatency > MaxReadLatency) begin : g_bad_latency
    $error("cve2_imem_resp_pipe: ReadLatency out of range");
  end

  logic        head_valid_q, head_valid_d;
  logic        head_err_q, head_err_d;
  imem_stage_t head_res;
  imem_stage_t out_stage;
  logic        tail_busy;

  // Head slot inputs: a new accept enters, and reset drops it.
  always_comb begin
    head_valid_d = in_valid_i & ~rst_i;
    head_err_d   = in_err_i;
  end

  // Head slot register.
  always_ff @(posedge clk_i) begin
    head_valid_q <= head_valid_d;
    head_err_q   <= head_err_d;
  end

  // Resolve the head: SRAM data for OK responses, the fixed pattern for errors.
  always_comb begin
    head_res.valid = head_valid_q;
    head_res.err   = head_err_q;
    head_res.data  = head_err_q ? ErrRdata : mem_rdata_i;
  end

  if (ReadLatency == 1) begin : g_direct
    assign out_stage = head_res;
    assign tail_busy = 1'b0;
  end else begin : g_shift
    localparam int unsigned NumStages = ReadLatency - 1;

    imem_stage_t stage_q [NumStages];
    imem_stage_t stage_d [NumStages];

    // Shift the resolved head down the chain, and clear valid bits on reset.
    always_comb begin
      stage_d[0] = head_res;
      for (int k = 1; k < NumStages; k++) begin
        stage_d[k] = stage_q[k-1];
      end
      if (rst_i) begin
        for (int k = 0; k < NumStages; k++) begin
          stage_d[k].valid = 1'b0;
        end
      end
    end

    // Stage registers.
    always_ff @(posedge clk_i) begin
      stage_q <= stage_d;
    end

    // Any valid stage means a response is still on its way.
    always_comb begin
      tail_busy = 1'b0;
      for (int k = 0; k < NumStages; k++) begin
        tail_busy = tail_busy | stage_q[k].valid;
      end
    end

    assign out_stage = stage_q[NumStages-1];
  end

  // Output qualification: data and err are zero unless rvalid is set, and
  // everything is held low while reset is asserted.
  always_comb begin
    rvalid_o = out_stage.valid & ~rst_i;
    err_o    = rvalid_o & out_stage.err;
    rdata_o  = rvalid_o ? out_stage.data : 32'h0000_0000;
    busy_o   = (head_valid_q | tail_busy) & ~rst_i;
  end

endmodule

// File: rtl/cve2_imem_responder.sv
// Instruction-fetch responder in front of a single-port SRAM.
// It grants every request unless stall_i is high or reset is active. It
// decodes the address window and starts the SRAM read in the accept
// cycle, then returns responses in order after exactly ReadLatency cycles.
module cve2_imem_responder
  import cve2_imem_pkg::*;
#(
  parameter logic [31:0] BaseAddr     = 32'h0000_0000,
  parameter int unsigned MemSizeWords = 1024,
  parameter int unsigned ReadLatency  = 1,
  parameter logic [31:0] ErrRdata     = 32'h0000_0000,
  localparam int unsigned AddrW       = $clog2(MemSizeWords)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             instr_req_i,
  input  logic [31:0]      instr_addr_i,
  output logic             instr_gnt_o,
  output logic             instr_rvalid_o,
  output logic [31:0]      instr_rdata_o,
  output logic             instr_err_o,
  input  logic             stall_i,
  output logic             mem_req_o,
  output logic [AddrW-1:0] mem_addr_o,
  input  logic [31:0]      mem_rdata_i,
  output logic             busy_o
);

  // The window size in bytes. The largest legal depth still fits in 32 bits.
  localparam logic [31:0] RangeBytes = 32'(4 * MemSizeWords);

  logic [31:0] offset;
  logic        in_range;

  // Grant, window decode and SRAM port. The subtraction wraps, so addresses
  // below BaseAddr fall far outside the window.
  always_comb begin
    instr_gnt_o = instr_req_i & ~stall_i & ~rst_i;
    offset      = instr_addr_i - BaseAddr;
    in_range    = offset < RangeBytes;
    mem_req_o   = instr_gnt_o & in_range;
    mem_addr_o  = offset[AddrW+1:2];
  end

  cve2_imem_resp_pipe #(
    .ReadLatency (ReadLatency),
    .ErrRdata    (ErrRdata)
  ) u_resp_pipe (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (instr_gnt_o),
    .in_err_i    (~in_range),
    .mem_rdata_i (mem_rdata_i),
    .rvalid_o    (instr_rvalid_o),
    .err_o       (instr_err_o),
    .rdata_o     (instr_rdata_o),
    .busy_o      (busy_o)
  );

endmodule
